whack_core: RTL and testbench

Parametrised whack-a-mole game engine. It replaces the fixed 8-LED, 3-bit-random, score-only game logic with N moles, a timed round, miss counting and speed levels. It sits between the keypad decoder (button pulses in) and the LED/VGA/7-segment drivers (mole vector, score, misses out).

---
 rtl/whack_pkg.sv | 20 ++
 rtl/whack_if.sv | 25 ++
 rtl/whack_lfsr.sv | 23 ++
 rtl/whack_core.sv | 191 +++++++++++++++++++
 tb/tb_whack_core.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole game engine: FSM states,
// LFSR taps, level stepping and the LFSR next-state helper.
package whack_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        SHOW = 2'd2,
        OVER = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam int          LEVEL_STEP = 32'sd8;
    localparam logic [1:0]  MAX_LEVEL  = 2'd3;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/whack_if.sv
// Keypad-side and display-side signals of the game engine, grouped as one
// bundle; the core takes the slave view, the stimulus/keypad side the master view.
interface whack_if #(
    parameter int N_MOLES = 32'sd8,
    parameter int SCORE_W = 32'sd6
);
    logic                 start;
    logic [N_MOLES-1:0]   button;
    logic [N_MOLES-1:0]   mole;
    logic [SCORE_W-1:0]   score;
    logic [SCORE_W-1:0]   misses;
    logic [1:0]           level;
    logic                 busy;
    logic                 game_over;

    modport master (
        output start, button,
        input  mole, score, misses, level, busy, game_over
    );

    modport slave (
        input  start, button,
        output mole, score, misses, level, busy, game_over
    );
endinterface

// File: rtl/whack_lfsr.sv
// Free-running 16-bit Galois LFSR; exposes the low byte used for mole selection.
module whack_lfsr
    import whack_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] o_rnd
);
    logic [15:0] r_lfsr;

    // A non-zero seed keeps the sequence out of the all-zero lock-up state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign o_rnd = r_lfsr[7:0];
endmodule

// File: rtl/whack_core.sv
// Whack-a-mole game engine: timed rounds, hit/miss scoring, speed levels.
// Optional streak bonus enabled by defining COMBO_BONUS_EN.
module whack_core
    import whack_pkg::*;
#(
    parameter int          N_MOLES     = 32'sd8,
    parameter int          SCORE_W     = 32'sd6,
    parameter int unsigned SLOT_CYC    = 32'd25000000,
    parameter int unsigned GAP_CYC     = 32'd5000000,
    parameter int          ROUND_SLOTS = 32'sd60,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic    clk,
    input  logic    rst_n,
    whack_if.slave  bus
);
    localparam int                 IDX_W     = $clog2(N_MOLES);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] v,
                                                   input logic [1:0]         inc);
        logic [SCORE_W:0] sum;
        sum = {1'b0, v} + {{(SCORE_W-1){1'b0}}, inc};
        return sum[SCORE_W] ? SCORE_MAX : sum[SCORE_W-1:0];
    endfunction

    state_t               r_state;
    logic [31:0]          r_tmr;
    logic [15:0]          r_slot_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [N_MOLES-1:0]   r_mole;
    logic [SCORE_W-1:0]   r_score;
    logic [SCORE_W-1:0]   r_misses;
    logic [1:0]           r_level;
    logic [2:0]           r_step_cnt;
    logic                 r_busy;
    logic                 r_game_over;
`ifdef COMBO_BONUS_EN
    logic [2:0]           r_streak;
    logic [2:0]           w_streak_nx;
`endif

    logic [7:0]           w_rnd;
    logic [7:0]           w_mod;
    logic [7:0]           w_alt;
    logic [IDX_W-1:0]     w_pick;
    logic [N_MOLES-1:0]   w_mole_nx;
    logic [31:0]          w_slot_len;
    logic [31:0]          w_slot_last;
    logic [31:0]          w_gap_last;
    logic                 w_show;
    logic                 w_hit;
    logic                 w_wrong;
    logic                 w_expire;
    logic [1:0]           w_miss_inc;
    logic [1:0]           w_hit_inc;
    logic [15:0]          w_slot_inc;
    logic                 w_round_end;

    whack_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .o_rnd (w_rnd)
    );

    // Never repeat the previously lit mole: bump to the next index on a collision.
    assign w_mod       = w_rnd % 8'(N_MOLES);
    assign w_alt       = (w_mod == 8'(N_MOLES - 1)) ? 8'd0 : w_mod + 8'd1;
    assign w_pick      = (w_mod == 8'(r_idx)) ? w_alt[IDX_W-1:0] : w_mod[IDX_W-1:0];
    assign w_mole_nx   = {{(N_MOLES-1){1'b0}}, 1'b1} << w_pick;

    assign w_slot_len  = 32'(SLOT_CYC) >> r_level;
    assign w_slot_last = (w_slot_len == 32'd0) ? 32'd0 : w_slot_len - 32'd1;
    assign w_gap_last  = (32'(GAP_CYC) == 32'd0) ? 32'd0 : 32'(GAP_CYC) - 32'd1;

    assign w_show      = (r_state == SHOW);
    assign w_hit       = w_show && bus.button[r_idx];
    assign w_wrong     = w_show && (bus.button != {N_MOLES{1'b0}}) && !bus.button[r_idx];
    assign w_expire    = w_show && (r_tmr >= w_slot_last) && !w_hit;
    assign w_miss_inc  = {1'b0, w_wrong} + {1'b0, w_expire};
    assign w_slot_inc  = r_slot_cnt + 16'd1;
    assign w_round_end = (w_slot_inc >= 16'(ROUND_SLOTS));

`ifdef COMBO_BONUS_EN
    assign w_streak_nx = (r_streak == 3'd7) ? 3'd7 : r_streak + 3'd1;
    assign w_hit_inc   = (w_streak_nx >= 3'd4) ? 2'd2 : 2'd1;
`else
    assign w_hit_inc   = 2'd1;
`endif

    // Game FSM with all outputs registered; start has priority in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_tmr       <= 32'd0;
            r_slot_cnt  <= 16'd0;
            r_idx       <= {IDX_W{1'b0}};
            r_mole      <= {N_MOLES{1'b0}};
            r_score     <= {SCORE_W{1'b0}};
            r_misses    <= {SCORE_W{1'b0}};
            r_level     <= 2'd0;
            r_step_cnt  <= 3'd0;
            r_busy      <= 1'b0;
            r_game_over <= 1'b0;
`ifdef COMBO_BONUS_EN
            r_streak    <= 3'd0;
`endif
        end else if (bus.start) begin
            r_state     <= GAP;
            r_tmr       <= 32'd0;
            r_slot_cnt  <= 16'd0;
            r_mole      <= {N_MOLES{1'b0}};
            r_score     <= {SCORE_W{1'b0}};
            r_misses    <= {SCORE_W{1'b0}};
            r_level     <= 2'd0;
            r_step_cnt  <= 3'd0;
            r_busy      <= 1'b1;
            r_game_over <= 1'b0;
`ifdef COMBO_BONUS_EN
            r_streak    <= 3'd0;
`endif
        end else begin
            case (r_state)
                IDLE: r_state <= IDLE;
                GAP: begin
                    if (r_tmr >= w_gap_last) begin
                        r_state <= SHOW;
                        r_tmr   <= 32'd0;
                        r_idx   <= w_pick;
                        r_mole  <= w_mole_nx;
                    end else begin
                        r_tmr   <= r_tmr + 32'd1;
                    end
                end
                SHOW: begin
                    if (w_hit || w_expire) begin
                        r_mole     <= {N_MOLES{1'b0}};
                        r_tmr      <= 32'd0;
                        r_slot_cnt <= w_slot_inc;
                        if (w_round_end) begin
                            r_state     <= OVER;
                            r_busy      <= 1'b0;
                            r_game_over <= 1'b1;
                        end else begin
                            r_state     <= GAP;
                        end
                    end else begin
                        r_tmr      <= r_tmr + 32'd1;
                    end
                    // A hit masks any wrong bits and a simultaneous expiry.
                    if (w_hit) begin
                        r_score <= sat_add(r_score, w_hit_inc);
`ifdef COMBO_BONUS_EN
                        r_streak <= w_streak_nx;
`endif
                        if (r_step_cnt == 3'(LEVEL_STEP - 1)) begin
                            r_step_cnt <= 3'd0;
                            if (r_level != MAX_LEVEL) begin
                                r_level <= r_level + 2'd1;
                            end else begin
                                r_level <= r_level;
                            end
                        end else begin
                            r_step_cnt <= r_step_cnt + 3'd1;
                        end
                    end else if (w_miss_inc != 2'd0) begin
                        r_misses <= sat_add(r_misses, w_miss_inc);
`ifdef COMBO_BONUS_EN
                        r_streak <= 3'd0;
`endif
                    end else begin
                        r_misses <= r_misses;
                    end
                end
                OVER: r_state <= OVER;
                default: begin
                    r_state <= IDLE;
                    r_mole  <= {N_MOLES{1'b0}};
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mole      = r_mole;
    assign bus.score     = r_score;
    assign bus.misses    = r_misses;
    assign bus.level     = r_level;
    assign bus.busy      = r_busy;
    assign bus.game_over = r_game_over;
endmodule

// File: tb/tb_whack_core.sv
// Scoreboard bench for whack_core: stimulus pushes cycle-tagged expectations,
// a negedge monitor pops and compares them and checks mole sequencing.
module tb_whack_core;
    localparam int N     = 8;
    localparam int SW    = 5;
    localparam int SLOT  = 20;
    localparam int GAPC  = 4;
    localparam int ROUND = 40;
    localparam int SMAX  = 31;
`ifdef COMBO_BONUS_EN
    localparam bit COMBO = 1'b1;
`else
    localparam bit COMBO = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    whack_if #(.N_MOLES(N), .SCORE_W(SW)) bus ();

    whack_core #(
        .N_MOLES(N), .SCORE_W(SW), .SLOT_CYC(SLOT), .GAP_CYC(GAPC),
        .ROUND_SLOTS(ROUND), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    due;
        string name;
        int    score;
        int    misses;
        int    level;
        bit    busy;
        bit    over;
        int    mmode;   // 0: dark, 1: exactly one lit
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    // reference model
    int m_score, m_misses, m_hits, m_streak, m_slots;
    bit m_busy, m_over;

    function automatic int m_level();
        return (m_hits / 8 > 3) ? 3 : m_hits / 8;
    endfunction

    function automatic void m_slot_exit();
        m_slots++;
        if (m_slots == ROUND) begin
            m_busy = 1'b0;
            m_over = 1'b1;
        end
    endfunction

    function automatic void m_start();
        m_score = 0; m_misses = 0; m_hits = 0; m_streak = 0; m_slots = 0;
        m_busy = 1'b1; m_over = 1'b0;
    endfunction

    function automatic void m_hit();
        int inc;
        m_hits++;
        m_streak++;
        inc = (COMBO && m_streak >= 4) ? 2 : 1;
        m_score = (m_score + inc > SMAX) ? SMAX : m_score + inc;
        m_slot_exit();
    endfunction

    function automatic void m_miss();
        m_misses = (m_misses + 1 > SMAX) ? SMAX : m_misses + 1;
        m_streak = 0;
    endfunction

    function automatic void push_sc(int due, string name, int mmode, int sc);
        exp_t e;
        e.due = due; e.name = name; e.score = sc; e.misses = m_misses;
        e.level = m_level(); e.busy = m_busy; e.over = m_over; e.mmode = mmode;
        sb.push_back(e);
    endfunction

    function automatic void push(int due, string name, int mmode);
        push_sc(due, name, mmode, m_score);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        m_start();
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_show();
        int k;
        k = 0;
        while (bus.mole == '0 && k < 100) begin
            tick();
            k++;
        end
        if (bus.mole == '0) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_show: mole dark for %0d cycles, required lit within 100", k);
        end
    endtask

    task automatic hit_now(string name);
        bus.button = bus.mole;
        m_hit();
        push(cyc + 1, name, 0);
        tick();
        bus.button = '0;
    endtask

    task automatic measure_show(int want, string name);
        int len;
        len = 1;
        while (len < 200) begin
            tick();
            if (bus.mole == '0) break;
            len++;
        end
        n_tests++;
        if (len != want) begin
            n_fail++;
            $display("FAIL %s: show lasted %0d clocks, required %0d", name, len, want);
        end
        m_miss();
        m_slot_exit();
        push(cyc, {name, "_expired"}, 0);
    endtask

    // Monitor: compare due expectations and check each newly lit mole.
    initial begin : monitor
        logic [N-1:0] prev_mole;
        logic [N-1:0] last_mole;
        prev_mole = '0;
        last_mole = '0;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                exp_t e;
                bit   mole_ok;
                e = sb.pop_front();
                n_tests++;
                mole_ok = (e.mmode == 0) ? (bus.mole == '0) : $onehot(bus.mole);
                if (e.due != cyc || int'(bus.score) != e.score || int'(bus.misses) != e.misses ||
                    int'(bus.level) != e.level || bus.busy != e.busy ||
                    bus.game_over != e.over || !mole_ok) begin
                    n_fail++;
                    $display("FAIL %s (cycle %0d, due %0d): got score=%0d misses=%0d level=%0d busy=%0b game_over=%0b mole=%b; required score=%0d misses=%0d level=%0d busy=%0b game_over=%0b mole_mode=%0d",
                             e.name, cyc, e.due, bus.score, bus.misses, bus.level, bus.busy,
                             bus.game_over, bus.mole, e.score, e.misses, e.level, e.busy,
                             e.over, e.mmode);
                end
            end
            if (!rst_n) begin
                prev_mole = '0;
                last_mole = '0;
            end else begin
                if (bus.mole != '0 && prev_mole == '0) begin
                    n_tests++;
                    if (!$onehot(bus.mole) || bus.mole == last_mole) begin
                        n_fail++;
                        $display("FAIL new_mole (cycle %0d): got mole=%b, required one-hot and different from %b",
                                 cyc, bus.mole, last_mole);
                    end
                    last_mole = bus.mole;
                end
                prev_mole = bus.mole;
            end
        end
    end

    initial begin : stimulus
        bus.start  = 1'b0;
        bus.button = '0;
        m_score = 0; m_misses = 0; m_hits = 0; m_streak = 0; m_slots = 0;
        m_busy = 1'b0; m_over = 1'b0;

        tick(); tick();
        push(cyc, "reset_state", 0);
        rst_n = 1'b1;
        tick();

        bus.button = '1;
        push(cyc + 1, "idle_press", 0);
        tick();
        bus.button = '0;

        // first round: gap length, first hit on the 3rd show clock
        pulse_start();
        for (int i = 0; i < GAPC; i++) begin
            push(cyc, "gap_dark", 0);
            tick();
        end
        push(cyc, "first_show", 1);
        tick(); tick();
        hit_now("hit_3rd_clock");
        bus.button = '1;
        push(cyc + 1, "gap_press", 0);
        tick();
        bus.button = '0;

        // wrong press then full-length expiry
        wait_show();
        tick();
        bus.button = ~bus.mole;
        m_miss();
        push(cyc + 1, "wrong_press", 1);
        tick();
        bus.button = '0;
        repeat (SLOT - 3) tick();
        push(cyc, "last_show_clock", 1);
        m_miss();
        m_slot_exit();
        push(cyc + 1, "expiry", 0);

        // hit on the expiry clock: hit only
        wait_show();
        repeat (SLOT - 1) tick();
        hit_now("hit_at_expiry");

        // levels
        while (m_hits < 8) begin
            wait_show();
            hit_now("hit_to_level1");
        end
        wait_show();
        measure_show(SLOT >> 1, "show_len_level1");
        while (m_hits < 24) begin
            wait_show();
            hit_now("hit_to_level3");
        end
        wait_show();
        measure_show(SLOT >> 3, "show_len_level3");
        while (m_busy) begin
            wait_show();
            hit_now("hit_to_round_end");
        end

        // frozen after round end, then restart
        for (int i = 0; i < 3; i++) begin
            bus.button = '1;
            push(cyc + 1, "over_frozen", 0);
            tick();
        end
        bus.button = '0;
        pulse_start();
        push(cyc, "restart_from_over", 0);

        // five straight hits
        for (int i = 0; i < 5; i++) begin
            wait_show();
            hit_now("straight_hit");
        end
`ifdef COMBO_BONUS_EN
        push_sc(cyc, "five_hit_score", 0, 7);
`else
        push_sc(cyc, "five_hit_score", 0, 5);
`endif

        // restart while a mole is lit
        wait_show();
        tick();
        pulse_start();
        push(cyc, "restart_busy", 0);

        // long run: distinct consecutive moles, score saturation, round wrap
        for (int s = 0; s < 200; s++) begin
            if (!bus.busy) begin
                pulse_start();
                push(cyc, "round_restart", 0);
            end
            wait_show();
            hit_now("long_run_hit");
        end

        // asynchronous reset in the middle of a show
        if (!bus.busy) pulse_start();
        wait_show();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.mole != '0 || bus.score != '0 || bus.misses != '0 || bus.level != 2'd0 ||
            bus.busy != 1'b0 || bus.game_over != 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got mole=%b score=%0d misses=%0d level=%0d busy=%0b game_over=%0b, required all zero",
                     bus.mole, bus.score, bus.misses, bus.level, bus.busy, bus.game_over);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();

        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
